// File: rtl/ws2812_rx.sv
// ws2812_rx: single-wire WS2812b receiver. Synchronizes the LED data line,
// measures each high pulse, classifies it as a 0 or 1 bit, assembles 24-bit
// GRB words MSB-first and flags the end-of-frame latch gap.
module ws2812_rx #(
  parameter int BIT_THRESH   = 9,   // high length (cycles) at or above which a bit is 1
  parameter int MIN_HIGH     = 2,   // shorter high pulses are glitches
  parameter int MAX_HIGH     = 31,  // MAX_HIGH+1 high cycles is a framing error
  parameter int RESET_CYCLES = 800  // low cycles forming the latch gap
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        din,
  output logic [23:0] data,
  output logic        valid,
  output logic        latch,
  output logic        err
);

  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(RESET_CYCLES + 1);

  localparam logic [HW-1:0] H_ONE  = HW'(1);
  localparam logic [HW-1:0] H_MIN  = HW'(MIN_HIGH);
  localparam logic [HW-1:0] H_THR  = HW'(BIT_THRESH);
  localparam logic [HW-1:0] H_MAX  = HW'(MAX_HIGH);
  localparam logic [HW-1:0] H_SAT  = HW'(MAX_HIGH + 1);
  localparam logic [LW-1:0] L_END  = LW'(RESET_CYCLES - 1);
  localparam logic [4:0]    LAST_BIT = 5'd23;

  typedef enum logic [1:0] {
    SYNC, // waiting for a full low gap before trusting the line
    IDLE, // gap seen, waiting for the first pulse of a frame
    HIGH, // measuring a high pulse
    LOW   // between pulses, timing the low gap
  } state_t;

  // Synchronizer and edge-detect history.
  logic s1, s2, s3;
  logic rise, fall;

  // Decoder state, current and next.
  state_t          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [LW-1:0]   lcnt_q, lcnt_d;
  logic [4:0]      bitcnt_q, bitcnt_d;
  logic [23:0]     sr_q, sr_d;
  logic            seen_q, seen_d;   // an accepted pulse since last latch/sync
  logic [23:0]     data_d;
  logic            valid_d, latch_d, err_d;
  logic            bit_val;

  // Two-flop synchronizer plus one history flop for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign bit_val = (hcnt_q >= H_THR);

  // State and datapath registers; outputs are registered here as well.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= SYNC;
      hcnt_q   <= '0;
      lcnt_q   <= '0;
      bitcnt_q <= '0;
      sr_q     <= '0;
      seen_q   <= 1'b0;
      data     <= '0;
      valid    <= 1'b0;
      latch    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      lcnt_q   <= lcnt_d;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
      seen_q   <= seen_d;
      data     <= data_d;
      valid    <= valid_d;
      latch    <= latch_d;
      err      <= err_d;
    end
  end

  // Next-state and next-output decode for the pulse-width receiver.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    lcnt_d   = lcnt_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    seen_d   = seen_q;
    data_d   = data;
    valid_d  = 1'b0;
    latch_d  = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      SYNC: begin
        // Edges are ignored; only an unbroken low gap releases the decoder.
        bitcnt_d = '0;
        seen_d   = 1'b0;
        if (s2) begin
          lcnt_d = '0;
        end else if (lcnt_q >= L_END) begin
          state_d = IDLE;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end

      IDLE: begin
        if (rise) begin
          hcnt_d  = H_ONE;
          state_d = HIGH;
        end
      end

      HIGH: begin
        if (s2) begin
          if (hcnt_q == H_MAX) begin
            // Pulse too long: abandon the frame and resynchronize.
            hcnt_d   = H_SAT;
            err_d    = 1'b1;
            bitcnt_d = '0;
            seen_d   = 1'b0;
            lcnt_d   = '0;
            state_d  = SYNC;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end else if (fall) begin
          state_d = LOW;
          // A glitch leaves lcnt alone so the surrounding gap keeps timing.
          if (hcnt_q >= H_MIN) begin
            sr_d   = {sr_q[22:0], bit_val};
            lcnt_d = '0;
            seen_d = 1'b1;
            if (bitcnt_q == LAST_BIT) begin
              data_d   = {sr_q[22:0], bit_val};
              valid_d  = 1'b1;
              bitcnt_d = '0;
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
        end
      end

      LOW: begin
        // A rise wins over a gap expiring in the same cycle.
        if (rise) begin
          hcnt_d  = H_ONE;
          state_d = HIGH;
        end else if (lcnt_q >= L_END) begin
          if (seen_q) begin
            latch_d = 1'b1;
            err_d   = (bitcnt_q != '0);
          end
          bitcnt_d = '0;
          seen_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end

      default: state_d = SYNC;
    endcase
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed bench for ws2812_rx. Words are pushed to a
// scoreboard as they are sent; a monitor pops and compares on each valid.
module tb_ws2812_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        din     = 1'b0;
  logic [23:0] data;
  logic        valid, latch, err;

  ws2812_rx dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .din     (din),
    .data    (data),
    .valid   (valid),
    .latch   (latch),
    .err     (err)
  );

  always #5 sys_clk = ~sys_clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  logic [23:0] exp_q[$];
  int unsigned vtime_q[$];
  logic [23:0] exp_word;

  int          n_valid = 0, n_latch = 0, n_err = 0, n_both = 0;
  int unsigned last_valid_cyc = 0, last_err_cyc = 0, last_fall_cyc = 0;
  int          b_valid, b_latch, b_err, b_both;
  int unsigned hold_start;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: samples on the falling edge, away from the active edge.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (valid) begin
        n_valid++;
        last_valid_cyc = cyc;
        vtime_q.push_back(cyc);
        check("valid_vs_latch", {31'd0, latch}, 32'd0);
        check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          check("sb_data", {8'd0, data}, {8'd0, exp_word});
        end
      end
      if (latch) n_latch++;
      if (err) begin
        n_err++;
        last_err_cyc = cyc;
      end
      if (latch && err) n_both++;
    end
  end

  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_bit(input logic b, input int h1, input int l1, input int h0, input int l0);
    drive(1'b1, b ? h1 : h0);
    last_fall_cyc = cyc;
    drive(1'b0, b ? l1 : l0);
  endtask

  task automatic send_bits(input logic [23:0] w, input int hi, input int lo,
                           input int h1 = 13, input int l1 = 7,
                           input int h0 = 6,  input int l0 = 14);
    for (int i = hi; i >= lo; i--) send_bit(w[i], h1, l1, h0, l0);
  endtask

  task automatic snap();
    b_valid = n_valid;
    b_latch = n_latch;
    b_err   = n_err;
    b_both  = n_both;
  endtask

  task automatic check_deltas(input string tag, input int dv, input int dl, input int de);
    check({tag, "_valid"}, n_valid - b_valid, dv);
    check({tag, "_latch"}, n_latch - b_latch, dl);
    check({tag, "_err"},   n_err   - b_err,   de);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  {8'd0, data}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_latch"}, {31'd0, latch}, 32'd0);
    check({tag, "_err"},   {31'd0, err}, 32'd0);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge sys_clk);
    check_outputs_zero("reset");
    sys_rst = 1'b0;

    // Basic frame: gap, one word, gap.
    snap();
    drive(1'b0, 810);
    exp_q.push_back(24'hA53CF0);
    send_bits(24'hA53CF0, 23, 0);
    drive(1'b0, 850);
    check_deltas("t1", 1, 1, 0);
    check("t1_data", {8'd0, data}, 32'h00A53CF0);
    check("t1_valid_latency", last_valid_cyc, last_fall_cyc + 3);

    // Word sent too soon after reset is ignored; the next frame decodes.
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    snap();
    drive(1'b0, 100);
    send_bits(24'h5A5A5A, 23, 0);
    drive(1'b0, 850);
    check_deltas("t2a", 0, 0, 0);
    snap();
    exp_q.push_back(24'h00FF00);
    send_bits(24'h00FF00, 23, 0);
    drive(1'b0, 850);
    check_deltas("t2b", 1, 1, 0);
    check("t2_data", {8'd0, data}, 32'h0000FF00);

    // One-cycle glitch between bits is discarded.
    snap();
    exp_q.push_back(24'h123456);
    send_bits(24'h123456, 23, 18);
    drive(1'b1, 1);
    drive(1'b0, 5);
    send_bits(24'h123456, 17, 0);
    drive(1'b0, 850);
    check_deltas("t3", 1, 1, 0);
    check("t3_data", {8'd0, data}, 32'h00123456);

    // Partial word: latch and err together, data unchanged.
    snap();
    send_bits(24'hABCDEF, 23, 14);
    drive(1'b0, 850);
    check_deltas("t4a", 0, 1, 1);
    check("t4_both", n_both - b_both, 1);
    check("t4_data_hold", {8'd0, data}, 32'h00123456);
    snap();
    exp_q.push_back(24'hFFFFFF);
    send_bits(24'hFFFFFF, 23, 0);
    drive(1'b0, 850);
    check_deltas("t4b", 1, 1, 0);
    check("t4_data", {8'd0, data}, 32'h00FFFFFF);

    // Stuck-high line: framing error, then ignored until a full gap.
    snap();
    send_bits(24'hA00000, 23, 19);
    hold_start = cyc;
    drive(1'b1, 40);
    drive(1'b0, 10);
    send_bits(24'h0F0F0F, 23, 0);
    drive(1'b0, 850);
    check_deltas("t5", 0, 0, 1);
    check("t5_err_time", last_err_cyc, hold_start + 34);
    check("t5_data_hold", {8'd0, data}, 32'h00FFFFFF);

    // Threshold boundary: high=9 decodes 1, high=8 decodes 0.
    snap();
    exp_q.push_back(24'hF0F0F0);
    exp_q.push_back(24'h0F0F0F);
    send_bits(24'hF0F0F0, 23, 0, 9, 11, 8, 12);
    send_bits(24'h0F0F0F, 23, 0, 9, 11, 8, 12);
    drive(1'b0, 850);
    check_deltas("t6a", 2, 1, 0);
    check("t6a_data", {8'd0, data}, 32'h000F0F0F);

    // Back-to-back words: valids spaced one word (480 cycles) apart.
    snap();
    vtime_q.delete();
    exp_q.push_back(24'h111111);
    exp_q.push_back(24'h333333);
    exp_q.push_back(24'h555555);
    send_bits(24'h111111, 23, 0);
    send_bits(24'h333333, 23, 0);
    send_bits(24'h555555, 23, 0);
    drive(1'b0, 850);
    check_deltas("t6b", 3, 1, 0);
    check("t6b_count", vtime_q.size(), 3);
    if (vtime_q.size() == 3) begin
      check("t6b_gap1", vtime_q[1] - vtime_q[0], 480);
      check("t6b_gap2", vtime_q[2] - vtime_q[1], 480);
    end

    // Reset mid-word discards progress and requires a fresh gap.
    snap();
    send_bits(24'h555555, 23, 12);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_outputs_zero("t6c_rst");
    sys_rst = 1'b0;
    send_bits(24'h555555, 11, 0);
    drive(1'b0, 850);
    check_deltas("t6c", 0, 0, 0);
    check("t6c_data", {8'd0, data}, 32'd0);

    check("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
